store_size: RTL and testbench
=============================

Name: store_size

Overview:
- Store-side counterpart of the load truncation path in the multicycle CPU.
- Executes sw/sh/sb by merging the low word/half/byte of register B into memory.
- Halfword and byte stores use a read-modify-write sequence. Word stores write directly.
- Sits between the control unit, which pulses `start`, and the single-port memory. It owns the memory address, write data and write enable for the duration of the store.

Parameters:
- MEM_RD_LAT, 1, memory read latency in cycles from address presented to Mem_rdata valid (legal 1..4)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle store request, sampled only in IDLE
- SSCtrl  input  2  store size: 01 word, 10 halfword, 11 byte, 00 illegal
- Addr  input  32  store address, used as given (no alignment masking)
- Data_B  input  32  register B source data
- Mem_rdata  input  32  memory read data
- Mem_addr  output  32  memory address, registered
- Mem_wdata  output  32  memory write data, registered
- Mem_wr  output  1  memory write enable, registered, one-cycle pulse
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse, coincident with done, for illegal SSCtrl

Behaviour:
- Reset (async, any state, including mid-operation):
  - state goes to IDLE; read counter cleared.
  - Mem_addr=0, Mem_wdata=0, Mem_wr=0, busy=0, done=0, error=0.
  - An interrupted store is abandoned. No write is issued after reset releases.
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE:
  - On start=1, latch Addr into Mem_addr and capture Data_B and SSCtrl internally.
  - SSCtrl=01: Mem_wdata<=Data_B, go to WRITE.
  - SSCtrl=10 or 11: go to READ, counter<=0.
  - SSCtrl=00: go to DONE with error flagged. No memory access.
  - start=0: stay in IDLE; all outputs hold their values except Mem_wr/done/error=0.
- READ:
  - Mem_addr held; Mem_wr=0.
  - Stay MEM_RD_LAT cycles (counter 0..MEM_RD_LAT-1), then go to MERGE.
- MERGE: one cycle. At its closing edge, Mem_wdata is loaded from Mem_rdata as follows:
  - halfword: {Mem_rdata[31:16], B[15:0]}
  - byte: {Mem_rdata[31:8], B[7:0]}
  - Then go to WRITE.
- WRITE: Mem_wr=1 for exactly this one cycle, with Mem_addr and Mem_wdata stable. Then go to DONE.
- DONE:
  - done=1 for one cycle; error=1 in the same cycle only for SSCtrl=00.
  - Return to IDLE.
- Latency, counted in cycles after the edge that accepts start:
  - word: WRITE in cycle 1, DONE in cycle 2.
  - half/byte: READ in cycles 1..MEM_RD_LAT, MERGE in MEM_RD_LAT+1, WRITE in MEM_RD_LAT+2, DONE in MEM_RD_LAT+3.
  - illegal: DONE in cycle 1.
- start while busy (including the DONE cycle) is ignored, not queued. The next request is accepted in the IDLE cycle after DONE.
- Data_B, Addr and SSCtrl changing after acceptance have no effect.
- Mem_addr and Mem_wdata retain their last values in IDLE.

Test Plan:
- Reset, then idle: outputs all 0. Word store with Addr=0x100, Data_B=0xDEADBEEF, SSCtrl=01 -> Mem_wr=1 in cycle 1 with Mem_addr=0x100 and Mem_wdata=0xDEADBEEF; done=1 in cycle 2; busy=1 in cycles 1-2; Mem_wr pulses exactly once.
- Halfword store, MEM_RD_LAT=1: Addr=0x40, Data_B=0x1234ABCD, memory word 0x55667788 -> Mem_wr in cycle 3 with Mem_wdata=0x5566ABCD; done in cycle 4.
- Byte store, MEM_RD_LAT=3: Data_B=0xFFFFFF5A, memory word 0x11223344 -> Mem_wdata=0x1122335A; Mem_wr in cycle 5; done in cycle 6.
- Illegal SSCtrl=00 -> done=1 and error=1 in cycle 1; Mem_wr stays 0 throughout.
- Request handling during a halfword store:
  - Second start during READ -> ignored, only one Mem_wr pulse.
  - Data_B changed to 0 during READ -> written data still uses the captured value.
  - Back-to-back start on the first IDLE cycle after DONE -> accepted.
- Assert reset during MERGE of a byte store -> all outputs 0 immediately. After release, no Mem_wr and no done occur until a new start.

Source files
------------

// File: rtl/store_size.sv
`default_nettype none
// ============================================================================
//  Module      : store_size
//  Description : Store-size unit for the multicycle CPU. Executes sw/sh/sb by
//                merging the low word/half/byte of register B into memory.
//                Word stores write directly. Halfword and byte stores do a
//                read-modify-write: read the addressed word, wait MEM_RD_LAT
//                cycles, merge, then write.
//
//  Parameters  : MEM_RD_LAT - memory read latency in cycles (legal 1..4)
//
//  Ports       : clk        - system clock, rising edge
//                reset      - asynchronous active-high reset
//                start      - one-cycle store request, sampled only in IDLE
//                SSCtrl     - store size: 01 word, 10 half, 11 byte, 00 illegal
//                Addr       - store address, used as given
//                Data_B     - register B source data
//                Mem_rdata  - memory read data
//                Mem_addr   - memory address (registered)
//                Mem_wdata  - memory write data (registered)
//                Mem_wr     - memory write enable, one-cycle pulse (registered)
//                busy       - high whenever the FSM is not IDLE (registered)
//                done       - one-cycle completion pulse (registered)
//                error      - one-cycle pulse with done for illegal SSCtrl
//
//  Revision    : 1.0 - initial release
// ============================================================================
module store_size #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  SSCtrl,
    input  logic [31:0] Addr,
    input  logic [31:0] Data_B,
    input  logic [31:0] Mem_rdata,
    output logic [31:0] Mem_addr,
    output logic [31:0] Mem_wdata,
    output logic        Mem_wr,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last count value of the READ wait; the counter runs 0..MEM_RD_LAT-1.
    localparam logic [2:0] C_RD_LAST = 3'(MEM_RD_LAT - 1);

    state_t      r_state;
    logic [2:0]  r_rd_cnt;
    // Only the low half of B can reach memory on the read-modify-write path;
    // word stores load Mem_wdata straight from Data_B at acceptance.
    logic [15:0] r_data_b_lo;
    logic        r_is_half;

    // Outputs are registered and updated on the same edge that enters the
    // state they belong to, so Mem_wr/done/error coincide with WRITE/DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd_cnt    <= 3'd0;
            r_data_b_lo <= 16'd0;
            r_is_half   <= 1'b0;
            Mem_addr    <= 32'd0;
            Mem_wdata   <= 32'd0;
            Mem_wr      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            Mem_wr <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        Mem_addr    <= Addr;
                        r_data_b_lo <= Data_B[15:0];
                        r_is_half   <= (SSCtrl == 2'b10);
                        busy        <= 1'b1;
                        case (SSCtrl)
                            2'b01: begin
                                Mem_wdata <= Data_B;
                                Mem_wr    <= 1'b1;
                                r_state   <= S_WRITE;
                            end
                            2'b10, 2'b11: begin
                                r_rd_cnt <= 3'd0;
                                r_state  <= S_READ;
                            end
                            default: begin
                                // Illegal size: finish immediately, no access.
                                done    <= 1'b1;
                                error   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end

                S_READ: begin
                    if (r_rd_cnt == C_RD_LAST) begin
                        r_state <= S_MERGE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 3'd1;
                    end
                end

                S_MERGE: begin
                    if (r_is_half) begin
                        Mem_wdata <= {Mem_rdata[31:16], r_data_b_lo};
                    end else begin
                        Mem_wdata <= {Mem_rdata[31:8], r_data_b_lo[7:0]};
                    end
                    Mem_wr  <= 1'b1;
                    r_state <= S_WRITE;
                end

                S_WRITE: begin
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_size.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_size
//  Description : Directed self-checking bench for store_size. Two instances
//                with read latency 1 and 3 share all inputs except start.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_store_size;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [1:0]  SSCtrl;
    logic [31:0] Addr, Data_B, Mem_rdata;

    logic [31:0] addr1, wdata1, addr3, wdata3;
    logic        wr1, busy1, done1, err1;
    logic        wr3, busy3, done3, err3;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    store_size #(.MEM_RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .SSCtrl(SSCtrl),
        .Addr(Addr), .Data_B(Data_B), .Mem_rdata(Mem_rdata),
        .Mem_addr(addr1), .Mem_wdata(wdata1), .Mem_wr(wr1),
        .busy(busy1), .done(done1), .error(err1)
    );

    store_size #(.MEM_RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .SSCtrl(SSCtrl),
        .Addr(Addr), .Data_B(Data_B), .Mem_rdata(Mem_rdata),
        .Mem_addr(addr3), .Mem_wdata(wdata3), .Mem_wr(wr3),
        .busy(busy3), .done(done3), .error(err3)
    );

    // Advance to 1 ns after the next rising edge (drive and sample point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        SSCtrl = 2'b00; Addr = 32'd0; Data_B = 32'd0; Mem_rdata = 32'd0;
        #3;
        tests++;
        if ({addr1, wdata1, wr1, busy1, done1, err1} !== 68'd0) begin
            failed++;
            $display("FAIL reset_lat1: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b, want all 0",
                     addr1, wdata1, wr1, busy1, done1, err1);
        end
        tests++;
        if ({addr3, wdata3, wr3, busy3, done3, err3} !== 68'd0) begin
            failed++;
            $display("FAIL reset_lat3: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b, want all 0",
                     addr3, wdata3, wr3, busy3, done3, err3);
        end
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if ({wr1, busy1, done1, err1} !== 4'b0000) begin
            failed++;
            $display("FAIL idle_after_reset: got wr=%b busy=%b done=%b err=%b, want 0000",
                     wr1, busy1, done1, err1);
        end
    endtask

    task automatic test_word();
        int wr_cnt = 0;
        Addr = 32'h100; Data_B = 32'hDEADBEEF; SSCtrl = 2'b01;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            if (wr1) wr_cnt++;
            tests++;
            if (wr1 !== (c == 1) || done1 !== (c == 2) || busy1 !== (c <= 2) || err1 !== 1'b0) begin
                failed++;
                $display("FAIL word_timing c%0d: got wr=%b done=%b busy=%b err=%b", c, wr1, done1, busy1, err1);
            end
            if (c == 1) begin
                tests++;
                if (addr1 !== 32'h100 || wdata1 !== 32'hDEADBEEF) begin
                    failed++;
                    $display("FAIL word_data: got addr=%h wdata=%h, want 00000100 deadbeef", addr1, wdata1);
                end
            end
        end
        tests++;
        if (wr_cnt !== 1) begin
            failed++;
            $display("FAIL word_wr_count: got %0d, want 1", wr_cnt);
        end
    endtask

    task automatic test_half_lat1();
        Addr = 32'h40; Data_B = 32'h1234ABCD; SSCtrl = 2'b10; Mem_rdata = 32'h55667788;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            tests++;
            if (wr1 !== (c == 3) || done1 !== (c == 4) || busy1 !== (c <= 4) || err1 !== 1'b0) begin
                failed++;
                $display("FAIL half_timing c%0d: got wr=%b done=%b busy=%b err=%b", c, wr1, done1, busy1, err1);
            end
            if (c == 3) begin
                tests++;
                if (addr1 !== 32'h40 || wdata1 !== 32'h5566ABCD) begin
                    failed++;
                    $display("FAIL half_data: got addr=%h wdata=%h, want 00000040 5566abcd", addr1, wdata1);
                end
            end
        end
    endtask

    task automatic test_byte_lat3();
        Addr = 32'h84; Data_B = 32'hFFFFFF5A; SSCtrl = 2'b11; Mem_rdata = 32'h11223344;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick();
            tests++;
            if (wr3 !== (c == 5) || done3 !== (c == 6) || busy3 !== (c <= 6) || err3 !== 1'b0) begin
                failed++;
                $display("FAIL byte_timing c%0d: got wr=%b done=%b busy=%b err=%b", c, wr3, done3, busy3, err3);
            end
            if (c == 5) begin
                tests++;
                if (addr3 !== 32'h84 || wdata3 !== 32'h1122335A) begin
                    failed++;
                    $display("FAIL byte_data: got addr=%h wdata=%h, want 00000084 1122335a", addr3, wdata3);
                end
            end
        end
    endtask

    task automatic test_illegal();
        Addr = 32'h500; Data_B = 32'h77777777; SSCtrl = 2'b00;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            tests++;
            if (wr1 !== 1'b0 || done1 !== (c == 1) || err1 !== (c == 1) || busy1 !== (c == 1)) begin
                failed++;
                $display("FAIL illegal c%0d: got wr=%b done=%b err=%b busy=%b", c, wr1, done1, err1, busy1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wr_cnt = 0;
        Addr = 32'h200; Data_B = 32'hCAFE1234; SSCtrl = 2'b10; Mem_rdata = 32'hAABBCCDD;
        start3 = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick();
            // Re-request in READ with corrupted operands; must be ignored.
            if (c == 1) begin
                start3 = 1'b1; Data_B = 32'd0; Addr = 32'h999; SSCtrl = 2'b11;
            end else if (c == 2) begin
                start3 = 1'b0;
            end else if (c == 6) begin
                // Request in DONE is ignored; held into the following IDLE
                // cycle where it is accepted as a word store.
                start3 = 1'b1; Data_B = 32'h0BADF00D; Addr = 32'h300; SSCtrl = 2'b01;
            end
            if (wr3) wr_cnt++;
            if (c <= 6) begin
                tests++;
                if (wr3 !== (c == 5) || done3 !== (c == 6) || busy3 !== 1'b1) begin
                    failed++;
                    $display("FAIL busy_req c%0d: got wr=%b done=%b busy=%b", c, wr3, done3, busy3);
                end
            end
            if (c == 5) begin
                tests++;
                if (addr3 !== 32'h200 || wdata3 !== 32'hAABB1234) begin
                    failed++;
                    $display("FAIL captured_data: got addr=%h wdata=%h, want 00000200 aabb1234", addr3, wdata3);
                end
            end
            if (c == 7) begin
                tests++;
                if (busy3 !== 1'b0 || wr3 !== 1'b0) begin
                    failed++;
                    $display("FAIL idle_after_done: got busy=%b wr=%b, want 0 0", busy3, wr3);
                end
            end
        end
        tests++;
        if (wr_cnt !== 1) begin
            failed++;
            $display("FAIL busy_wr_count: got %0d, want 1", wr_cnt);
        end
        tick();
        start3 = 1'b0;
        tests++;
        if (wr3 !== 1'b1 || busy3 !== 1'b1 || addr3 !== 32'h300 || wdata3 !== 32'h0BADF00D) begin
            failed++;
            $display("FAIL back_to_back: got wr=%b busy=%b addr=%h wdata=%h, want 1 1 00000300 0badf00d",
                     wr3, busy3, addr3, wdata3);
        end
        tick();
        tests++;
        if (done3 !== 1'b1 || wr3 !== 1'b0) begin
            failed++;
            $display("FAIL back_to_back_done: got done=%b wr=%b, want 1 0", done3, wr3);
        end
        tick();
    endtask

    task automatic test_reset_mid_merge();
        Addr = 32'h88; Data_B = 32'h000000EE; SSCtrl = 2'b11; Mem_rdata = 32'h99999999;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick(); tick(); tick();
        // Cycle 4 is MERGE for latency 3.
        tests++;
        if (busy3 !== 1'b1 || wr3 !== 1'b0) begin
            failed++;
            $display("FAIL pre_reset_merge: got busy=%b wr=%b, want 1 0", busy3, wr3);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({addr3, wdata3, wr3, busy3, done3, err3} !== 68'd0) begin
            failed++;
            $display("FAIL async_reset: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b, want all 0",
                     addr3, wdata3, wr3, busy3, done3, err3);
        end
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            tests++;
            if (wr3 !== 1'b0 || done3 !== 1'b0 || busy3 !== 1'b0) begin
                failed++;
                $display("FAIL post_reset c%0d: got wr=%b done=%b busy=%b, want 0 0 0", c, wr3, done3, busy3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        tick();
        test_half_lat1();
        test_byte_lat3();
        test_illegal();
        test_back_to_back();
        test_reset_mid_merge();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
